// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: ALU and load offers, halt handshake,
// and the registered register-file write port.
interface wb_arbiter_if #(
    parameter int XLEN = 32
);
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            alu_ready;

    logic            ld_valid;
    logic [4:0]      ld_rd;
    logic [XLEN-1:0] ld_data;
    logic [2:0]      ld_funct3;
    logic [1:0]      ld_addr_lo;
    logic            ld_ready;

    logic            halt_req;
    logic            halt_done;

    logic [4:0]      rd_num;
    logic [XLEN-1:0] rd_data;
    logic            rd_we;

    modport master (
        output alu_valid,
        output alu_rd,
        output alu_data,
        input  alu_ready,
        output ld_valid,
        output ld_rd,
        output ld_data,
        output ld_funct3,
        output ld_addr_lo,
        input  ld_ready,
        output halt_req,
        input  halt_done,
        input  rd_num,
        input  rd_data,
        input  rd_we
    );

    modport slave (
        input  alu_valid,
        input  alu_rd,
        input  alu_data,
        output alu_ready,
        input  ld_valid,
        input  ld_rd,
        input  ld_data,
        input  ld_funct3,
        input  ld_addr_lo,
        output ld_ready,
        input  halt_req,
        output halt_done,
        output rd_num,
        output rd_data,
        output rd_we
    );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU results and buffered loads into one
// registered regfile write. Define WB_LOAD_EXT_EN to format loads here.
module wb_arbiter #(
    parameter int XLEN     = 32,
    parameter int LD_DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    wb_arbiter_if.slave bus
);
    localparam int PW = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;
    localparam int CW = $clog2(LD_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(LD_DEPTH);
    localparam logic [PW-1:0] LAST_C  = PW'(LD_DEPTH - 1);

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
`ifdef WB_LOAD_EXT_EN
        logic [2:0]      funct3;
        logic [1:0]      addr_lo;
`endif
    } ld_ent_t;

    typedef enum logic {
        S_RUN,
        S_DONE
    } halt_state_t;

    ld_ent_t         fifo_mem [LD_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    halt_state_t     state;
    halt_state_t     state_next;
    logic            halt_done_int;
    logic            halt_ok;

    logic            ld_ready_int;
    logic            alu_ready_int;
    logic            ld_acc;
    logic            alu_acc;
    logic            fifo_empty;

    logic            pick_head;
    logic            pick_byp;
    logic            pick_alu;
    logic            enq;
    logic            deq;

    ld_ent_t         ld_in;
    ld_ent_t         head;
    logic            sel_valid;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;

    logic            rd_we_q;
    logic [4:0]      rd_num_q;
    logic [XLEN-1:0] rd_data_q;

    function automatic logic [PW-1:0] ptr_inc(
        input logic [PW-1:0] p
    );
        return (p == LAST_C) ? '0 : p + 1'b1;
    endfunction

`ifdef WB_LOAD_EXT_EN
    // Lane pick plus sign/zero extension, applied when a load is chosen.
    function automatic logic [XLEN-1:0] load_fmt(
        input ld_ent_t e
    );
        logic [7:0]      b;
        logic [15:0]     h;
        logic [XLEN-1:0] r;
        unique case (e.addr_lo)
            2'd0: b = e.data[7:0];
            2'd1: b = e.data[15:8];
            2'd2: b = e.data[23:16];
            2'd3: b = e.data[31:24];
        endcase
        h = e.addr_lo[1] ? e.data[31:16] : e.data[15:0];
        case (e.funct3)
            3'b000:  r = {{(XLEN-8){b[7]}}, b};
            3'b001:  r = {{(XLEN-16){h[15]}}, h};
            3'b100:  r = {{(XLEN-8){1'b0}}, b};
            3'b101:  r = {{(XLEN-16){1'b0}}, h};
            default: r = e.data;
        endcase
        return r;
    endfunction
`else
    function automatic logic [XLEN-1:0] load_fmt(
        input ld_ent_t e
    );
        return e.data;
    endfunction

    logic unused_ld_fmt;
    assign unused_ld_fmt = ^{bus.ld_funct3, bus.ld_addr_lo};
`endif

    always_comb begin
        ld_in      = '0;
        ld_in.rd   = bus.ld_rd;
        ld_in.data = bus.ld_data;
`ifdef WB_LOAD_EXT_EN
        ld_in.funct3  = bus.ld_funct3;
        ld_in.addr_lo = bus.ld_addr_lo;
`endif
    end

    assign fifo_empty = (count == '0);
    assign head       = fifo_mem[rd_ptr];

    assign ld_ready_int  = !rst && !halt_done_int
                         && (count < DEPTH_C);
    assign alu_ready_int = !rst && !halt_done_int
                         && fifo_empty && !bus.ld_valid;

    assign ld_acc  = bus.ld_valid && ld_ready_int;
    assign alu_acc = bus.alu_valid && alu_ready_int;

    // Mutually exclusive: alu_acc already implies empty FIFO and no load.
    assign pick_head = !fifo_empty;
    assign pick_byp  = fifo_empty && ld_acc;
    assign pick_alu  = alu_acc;

    assign deq = pick_head;
    assign enq = ld_acc && !fifo_empty;

    always_comb begin
        sel_valid = 1'b0;
        sel_rd    = '0;
        sel_data  = '0;
        unique case (1'b1)
            pick_head: begin
                sel_valid = 1'b1;
                sel_rd    = head.rd;
                sel_data  = load_fmt(head);
            end
            pick_byp: begin
                sel_valid = 1'b1;
                sel_rd    = ld_in.rd;
                sel_data  = load_fmt(ld_in);
            end
            pick_alu: begin
                sel_valid = 1'b1;
                sel_rd    = bus.alu_rd;
                sel_data  = bus.alu_data;
            end
            default: begin
                sel_valid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= ptr_inc(wr_ptr);
            if (deq) rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(enq) - CW'(deq);
        end
    end

    always_ff @(posedge clk) begin
        if (enq) fifo_mem[wr_ptr] <= ld_in;
    end

    // x0 writes are consumed and shown on the port, but never enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_we_q   <= 1'b0;
            rd_num_q  <= '0;
            rd_data_q <= '0;
        end else begin
            rd_we_q <= sel_valid && (sel_rd != 5'd0);
            if (sel_valid) begin
                rd_num_q  <= sel_rd;
                rd_data_q <= sel_data;
            end
        end
    end

    assign halt_ok = bus.halt_req && fifo_empty
                   && !bus.ld_valid && !bus.alu_valid
                   && !rd_we_q;

    always_ff @(posedge clk) begin
        if (rst) state <= S_RUN;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_RUN:  if (halt_ok) state_next = S_DONE;
            S_DONE: state_next = S_DONE;
        endcase
    end

    always_comb begin
        halt_done_int = (state == S_DONE);
    end

    assign bus.ld_ready  = ld_ready_int;
    assign bus.alu_ready = alu_ready_int;
    assign bus.halt_done = halt_done_int;
    assign bus.rd_we     = rd_we_q;
    assign bus.rd_num    = rd_num_q;
    assign bus.rd_data   = rd_data_q;
endmodule
